// File: rtl/led_pattern_sequencer.sv
// Mode-selectable, prescaled 8-LED pattern sequencer; mode changes land only on step edges.
// Optional BOUNCE mode is compiled in when LED_SEQ_BOUNCE_EN is defined.
module led_pattern_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_load,
    input  logic       run,
    output logic [1:0] mode_cur,
    output logic       mode_pending,
    output logic       tick,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       led5,
    output logic       led6,
    output logic       led7
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_RIPPLE_L = 2'd1,
        MODE_BOUNCE   = 2'd2,
        MODE_RIPPLE_R = 2'd3
    } mode_t;

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_pat;
    mode_t         r_mode_cur;
    mode_t         r_pend_mode;
    logic          r_pend;
    logic          r_tick;

    logic          w_step;
    mode_t         w_req;
    logic [7:0]    w_pat_next;

`ifdef LED_SEQ_BOUNCE_EN
    logic          r_dir_left;
    logic          w_dir_next;
`endif

    assign w_step = run && (r_cnt == CNT_LAST);

    // Without BOUNCE support a request for mode 2 degrades to RIPPLE_L at capture time.
    always_comb begin
        w_req = mode_t'(mode_req);
`ifndef LED_SEQ_BOUNCE_EN
        if (mode_req == 2'd2) begin
            w_req = MODE_RIPPLE_L;
        end
`endif
    end

    always_comb begin
        w_pat_next = r_pat;
`ifdef LED_SEQ_BOUNCE_EN
        w_dir_next = r_dir_left;
`endif
        if (r_pend) begin
            case (r_pend_mode)
                MODE_OFF:      w_pat_next = 8'h00;
                MODE_RIPPLE_L: w_pat_next = 8'h01;
                MODE_BOUNCE:   w_pat_next = 8'h01;
                MODE_RIPPLE_R: w_pat_next = 8'h80;
                default:       w_pat_next = 8'h00;
            endcase
`ifdef LED_SEQ_BOUNCE_EN
            w_dir_next = 1'b1;
`endif
        end else begin
            case (r_mode_cur)
                MODE_OFF:      w_pat_next = 8'h00;
                MODE_RIPPLE_L: w_pat_next = {r_pat[6:0], r_pat[7]};
                MODE_RIPPLE_R: w_pat_next = {r_pat[0], r_pat[7:1]};
`ifdef LED_SEQ_BOUNCE_EN
                MODE_BOUNCE: begin
                    // Flip on arrival at an end so the end value is shown only once.
                    w_pat_next = r_dir_left ? {r_pat[6:0], 1'b0} : {1'b0, r_pat[7:1]};
                    if (w_pat_next == 8'h80) begin
                        w_dir_next = 1'b0;
                    end else if (w_pat_next == 8'h01) begin
                        w_dir_next = 1'b1;
                    end
                end
`endif
                default:       w_pat_next = r_pat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pat       <= 8'h00;
            r_mode_cur  <= MODE_OFF;
            r_pend_mode <= MODE_OFF;
            r_pend      <= 1'b0;
            r_tick      <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir_left  <= 1'b1;
`endif
        end else begin
            r_tick <= w_step;
            if (run) begin
                r_cnt <= w_step ? '0 : r_cnt + 1'b1;
            end
            if (w_step) begin
                r_pat <= w_pat_next;
`ifdef LED_SEQ_BOUNCE_EN
                r_dir_left <= w_dir_next;
`endif
                if (r_pend) begin
                    r_mode_cur <= r_pend_mode;
                end
            end
            // A load coinciding with a step survives it and waits for the next one.
            if (mode_load) begin
                r_pend_mode <= w_req;
                r_pend      <= 1'b1;
            end else if (w_step) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign mode_cur     = r_mode_cur;
    assign mode_pending = r_pend;
    assign tick         = r_tick;
    assign led0         = r_pat[0];
    assign led1         = r_pat[1];
    assign led2         = r_pat[2];
    assign led3         = r_pat[3];
    assign led4         = r_pat[4];
    assign led5         = r_pat[5];
    assign led6         = r_pat[6];
    assign led7         = r_pat[7];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer (TICK_DIV=4); expected {mode, pattern}
// per step is queued when stimulus is applied and popped on each tick.
module tb_led_pattern_sequencer;
    localparam int TICK_DIV = 4;

    logic       clk;
    logic       reset;
    logic [1:0] mode_req;
    logic       mode_load;
    logic       run;
    logic [1:0] mode_cur;
    logic       mode_pending;
    logic       tick;
    logic       led0, led1, led2, led3, led4, led5, led6, led7;
    logic [7:0] leds;

    int         errors;
    int         checks;
    int         exp_cnt;
    logic [9:0] exp_q[$];

    logic [7:0] bounce_tbl [0:13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                      8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    assign leds = {led7, led6, led5, led4, led3, led2, led1, led0};

    led_pattern_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_load(mode_load), .run(run),
        .mode_cur(mode_cur), .mode_pending(mode_pending), .tick(tick),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3),
        .led4(led4), .led5(led5), .led6(led6), .led7(led7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge: predict tick from the bench's own phase counter, check, and pop on steps.
    task automatic clock_cycle();
        bit         exp_step;
        logic [9:0] exp;
        exp_step = !reset && run && (exp_cnt == TICK_DIV - 1);
        if (reset) exp_cnt = 0;
        else if (run) exp_cnt = exp_step ? 0 : exp_cnt + 1;
        @(posedge clk);
        #1;
        checks++;
        if (tick !== exp_step) begin
            errors++;
            $display("FAIL tick: got %b expected %b at %0t", tick, exp_step, $time);
        end
        if (reset) begin
            exp_q.delete();
        end else if (exp_step && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({mode_cur, leds} !== exp) begin
                errors++;
                $display("FAIL step: got mode=%0d leds=%h expected mode=%0d leds=%h at %0t",
                         mode_cur, leds, exp[9:8], exp[7:0], $time);
            end else begin
                $display("step ok: mode=%0d leds=%h at %0t", mode_cur, leds, $time);
            end
        end
    endtask

    task automatic run_until_empty(input int max_cycles, output int used);
        used = 0;
        while (exp_q.size() > 0 && used < max_cycles) begin
            clock_cycle();
            used++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d steps still expected after %0d cycles", exp_q.size(), used);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; mode_load = 1'b0; mode_req = 2'd0;
        clock_cycle();
        clock_cycle();
        checks++;
        if ({mode_cur, mode_pending, leds} !== 11'd0) begin
            errors++;
            $display("FAIL reset: got mode=%0d pend=%b leds=%h expected 0 0 00",
                     mode_cur, mode_pending, leds);
        end
        reset = 1'b0;
    endtask

    task automatic test_ripple_l();
        int used;
        run = 1'b1; mode_req = 2'd1; mode_load = 1'b1;
        exp_q.push_back({2'd1, 8'h01});
        for (int i = 1; i < 10; i++) exp_q.push_back({2'd1, 8'(1 << (i % 8))});
        clock_cycle();
        mode_load = 1'b0;
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL ripple_l_pending: got %b expected 1", mode_pending);
        end
        run_until_empty(200, used);
    endtask

    task automatic test_ripple_r();
        int used;
        mode_req = 2'd3; mode_load = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back({2'd3, 8'(8'h80 >> (i % 8))});
        clock_cycle();
        mode_load = 1'b0;
        run_until_empty(200, used);
    endtask

    task automatic test_bounce();
        int used;
        mode_req = 2'd2; mode_load = 1'b1;
        for (int i = 0; i < 20; i++) begin
`ifdef LED_SEQ_BOUNCE_EN
            exp_q.push_back({2'd2, bounce_tbl[i % 14]});
`else
            exp_q.push_back({2'd1, 8'(1 << (i % 8))});
`endif
        end
        clock_cycle();
        mode_load = 1'b0;
        run_until_empty(400, used);
    endtask

    task automatic test_load_on_step();
        int used;
        clock_cycle();
        clock_cycle();
        clock_cycle();
`ifdef LED_SEQ_BOUNCE_EN
        exp_q.push_back({2'd2, 8'h40});
`else
        exp_q.push_back({2'd1, 8'h10});
`endif
        exp_q.push_back({2'd0, 8'h00});
        mode_req = 2'd0; mode_load = 1'b1;
        clock_cycle();
        mode_load = 1'b0;
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL load_on_step_pending: got %b expected 1", mode_pending);
        end
        run_until_empty(200, used);
        checks++;
        if (mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL load_on_step_cleared: got %b expected 0", mode_pending);
        end
    endtask

    task automatic test_back_to_back();
        int used;
        mode_req = 2'd1; mode_load = 1'b1;
        clock_cycle();
        mode_req = 2'd3;
        clock_cycle();
        mode_load = 1'b0;
        exp_q.push_back({2'd3, 8'h80});
        run_until_empty(200, used);
    endtask

    task automatic test_freeze();
        int used;
        exp_q.push_back({2'd3, 8'h40});
        clock_cycle();
        clock_cycle();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clock_cycle();
            checks++;
            if ({mode_cur, leds} !== {2'd3, 8'h80}) begin
                errors++;
                $display("FAIL freeze: got mode=%0d leds=%h expected mode=3 leds=80",
                         mode_cur, leds);
            end
        end
        run = 1'b1;
        run_until_empty(200, used);
        checks++;
        if (used != 2) begin
            errors++;
            $display("FAIL freeze_resume: step after %0d cycles expected 2", used);
        end
    endtask

    task automatic test_reset_mid();
        int used;
        mode_req = 2'd1; mode_load = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd1, 8'(1 << i)});
        clock_cycle();
        mode_load = 1'b0;
        run_until_empty(200, used);
        mode_req = 2'd3; mode_load = 1'b1;
        clock_cycle();
        mode_load = 1'b0;
        checks++;
        if ({mode_pending, leds} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL reset_mid_pre: got pend=%b leds=%h expected 1 10", mode_pending, leds);
        end
        reset = 1'b1;
        clock_cycle();
        reset = 1'b0;
        checks++;
        if ({mode_cur, mode_pending, leds} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: got mode=%0d pend=%b leds=%h expected 0 0 00",
                     mode_cur, mode_pending, leds);
        end
        exp_q.push_back({2'd0, 8'h00});
        exp_q.push_back({2'd0, 8'h00});
        run_until_empty(200, used);
        checks++;
        if (used != 2 * TICK_DIV) begin
            errors++;
            $display("FAIL reset_mid_period: two steps took %0d cycles expected %0d",
                     used, 2 * TICK_DIV);
        end
    endtask

    initial begin
        errors = 0; checks = 0; exp_cnt = 0;
        reset = 1'b1; run = 1'b0; mode_load = 1'b0; mode_req = 2'd0;
        test_reset();
        test_ripple_l();
        test_ripple_r();
        test_bounce();
        test_load_on_step();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
